data_mem_responder: RTL and testbench

- Data-memory responder on the far side of the CPU's data-memory port.
- Serves the word read/write requests and the 256-bit block read/write requests the pipeline (or a future D-cache) issues.
- Returns block completion through the block valid strobes after a fixed, parameterised latency.
- Intended as the synthesizable data-memory model behind the CPU top in simulation and FPGA builds.

---
 rtl/data_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_data_mem_responder.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory responder behind the CPU data-memory port.
//               Word path: combinational read and byte-lane merged writes.
//               Block path: 256-bit (8-word) reads/writes completed through a
//               one-cycle valid strobe after BLK_LATENCY+1 cycles.
//               Byte order is big-endian (offset 0 = bits [31:24]).
// Ports       : CLK                   - clock, all state updates on rising edge
//               RESET                 - synchronous active-low reset
//               data_address_2DM      - byte address (block uses [31:5])
//               MemRead_2DM           - word read request (read is always live)
//               MemWrite_2DM          - word write request
//               data_write_2DM        - right-justified word write data
//               data_write_size_2DM   - bytes to write: 1..3, 0 means 4
//               data_read_fDM         - aligned word read data
//               dBlkRead/dBlkWrite    - level block requests, held until valid
//               block_write_2DM       - block write data (word k at [32k+31:32k])
//               block_read_fDM        - block read data, held until next read
//               block_read_fDM_valid  - one-cycle pulse, block read complete
//               block_write_fDM_valid - one-cycle pulse, block write committed
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 12,
  parameter int BLK_LATENCY = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DM,
  input  logic         MemRead_2DM,
  input  logic         MemWrite_2DM,
  input  logic [31:0]  data_write_2DM,
  input  logic [1:0]   data_write_size_2DM,
  output logic [31:0]  data_read_fDM,
  input  logic         dBlkRead,
  input  logic         dBlkWrite,
  input  logic [255:0] block_write_2DM,
  output logic [255:0] block_read_fDM,
  output logic         block_read_fDM_valid,
  output logic         block_write_fDM_valid
);

  localparam int       c_DEPTH    = 1 << ADDR_WIDTH;
  localparam int       c_BIDX_W   = ADDR_WIDTH - 3;
  localparam logic [3:0] c_CNT_LOAD = 4'(BLK_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_WAIT = 2'd1,
    READ_WAIT  = 2'd2,
    DONE       = 2'd3
  } state_e;

  logic [31:0]          mem_q [c_DEPTH];

  state_e               state_q;
  logic [3:0]           cnt_q;
  logic [c_BIDX_W-1:0]  blk_idx_q;
  logic [255:0]         blk_wdata_q;
  logic [255:0]         blk_rdata_q;
  logic                 rvalid_q;
  logic                 wvalid_q;

  logic [ADDR_WIDTH-1:0] w_widx;
  logic [c_BIDX_W-1:0]   w_bidx;
  logic [2:0]            w_nbytes;
  logic [1:0]            w_off;
  logic [3:0]            w_lmask;
  logic [31:0]           w_ldata;
  logic [31:0]           w_merged;
  logic [255:0]          w_blk_rd;
  logic                  w_blk_commit;
  logic                  w_unused;

  // Upper address bits alias (modulo wrap); the read strobe is not needed
  // because the read port is always live.
  assign w_unused = ^{data_address_2DM[31:ADDR_WIDTH+2], MemRead_2DM};

  assign w_widx = data_address_2DM[ADDR_WIDTH+1:2];
  assign w_bidx = data_address_2DM[ADDR_WIDTH+1:5];

  assign data_read_fDM = mem_q[w_widx];

  // Byte-lane write: left-justify the n data bytes to offset 0, then slide
  // them right by the byte offset. Bytes shifted past offset 3 fall off the
  // end instead of wrapping into the next word. Mask bit 3 is offset 0.
  assign w_nbytes = (data_write_size_2DM == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DM};
  assign w_off    = (data_write_size_2DM == 2'd0) ? 2'd0 : data_address_2DM[1:0];
  assign w_lmask  = 4'((4'b1111 << (3'd4 - w_nbytes)) >> w_off);
  assign w_ldata  = (data_write_2DM << {(3'd4 - w_nbytes), 3'b000}) >> {w_off, 3'b000};

  always_comb begin
    w_merged = mem_q[w_widx];
    for (int i = 0; i < 4; i++) begin
      if (w_lmask[i]) begin
        w_merged[8*i +: 8] = w_ldata[8*i +: 8];
      end
    end
  end

  always_comb begin
    w_blk_rd = '0;
    for (int k = 0; k < 8; k++) begin
      w_blk_rd[32*k +: 32] = mem_q[{blk_idx_q, 3'(k)}];
    end
  end

  // Block commit happens on the final wait edge only if the request is still
  // held and reset is not asserted on that edge.
  assign w_blk_commit = RESET && (state_q == WRITE_WAIT) && dBlkWrite && (cnt_q == 4'd0);

  // Backing array: contents survive reset. The block commit is written after
  // the word write so it wins when both target the same word.
  always_ff @(posedge CLK) begin
    if (MemWrite_2DM) begin
      mem_q[w_widx] <= w_merged;
    end
    if (w_blk_commit) begin
      for (int k = 0; k < 8; k++) begin
        mem_q[{blk_idx_q, 3'(k)}] <= blk_wdata_q[32*k +: 32];
      end
    end
  end

  // Block FSM with registered valid strobes.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      rvalid_q    <= 1'b0;
      wvalid_q    <= 1'b0;
      blk_rdata_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (dBlkWrite) begin
            blk_idx_q   <= w_bidx;
            blk_wdata_q <= block_write_2DM;
            cnt_q       <= c_CNT_LOAD;
            state_q     <= WRITE_WAIT;
          end else if (dBlkRead) begin
            blk_idx_q <= w_bidx;
            cnt_q     <= c_CNT_LOAD;
            state_q   <= READ_WAIT;
          end
        end
        WRITE_WAIT: begin
          if (!dBlkWrite) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            wvalid_q <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        READ_WAIT: begin
          if (!dBlkRead) begin
            state_q <= IDLE;
          end else if (cnt_q == 4'd0) begin
            blk_rdata_q <= w_blk_rd;
            rvalid_q    <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          // Requests seen here are ignored; a still-held request is taken
          // as new in the following IDLE cycle.
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign block_read_fDM        = blk_rdata_q;
  assign block_read_fDM_valid  = rvalid_q;
  assign block_write_fDM_valid = wvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. A byte-addressed
//               big-endian reference memory predicts word and block reads;
//               block completion latency is measured in cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int AW    = 12;
  localparam int LAT   = 4;
  localparam int WORDS = 1 << AW;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DM;
  logic         MemRead_2DM;
  logic         MemWrite_2DM;
  logic [31:0]  data_write_2DM;
  logic [1:0]   data_write_size_2DM;
  logic [31:0]  data_read_fDM;
  logic         dBlkRead;
  logic         dBlkWrite;
  logic [255:0] block_write_2DM;
  logic [255:0] block_read_fDM;
  logic         block_read_fDM_valid;
  logic         block_write_fDM_valid;

  always #5 CLK = ~CLK;

  data_mem_responder #(
    .ADDR_WIDTH  (AW),
    .BLK_LATENCY (LAT)
  ) u_dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .data_address_2DM      (data_address_2DM),
    .MemRead_2DM           (MemRead_2DM),
    .MemWrite_2DM          (MemWrite_2DM),
    .data_write_2DM        (data_write_2DM),
    .data_write_size_2DM   (data_write_size_2DM),
    .data_read_fDM         (data_read_fDM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
  );

  // Reference memory, one entry per byte.
  logic [7:0] mb [WORDS*4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  function automatic logic [31:0] mword(input int idx);
    return {mb[4*idx], mb[4*idx+1], mb[4*idx+2], mb[4*idx+3]};
  endfunction

  task automatic mset_word(input int idx, input logic [31:0] d);
    for (int j = 0; j < 4; j++) mb[4*idx+j] = 8'(d >> (8*(3-j)));
  endtask

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int n, off, idx;
    n   = (s == 2'd0) ? 4 : int'(s);
    off = (s == 2'd0) ? 0 : int'(a % 4);
    idx = widx(a);
    for (int j = 0; j < n; j++)
      if (off + j < 4) mb[4*idx+off+j] = 8'(d >> (8*(n-1-j)));
  endtask

  function automatic int bbase(input logic [31:0] a);
    return int'((a >> 5) % (WORDS/8)) * 8;
  endfunction

  function automatic logic [255:0] mblock(input logic [31:0] a);
    logic [255:0] b;
    for (int k = 0; k < 8; k++) b[32*k +: 32] = mword(bbase(a) + k);
    return b;
  endfunction

  task automatic mblkwrite(input logic [31:0] a, input logic [255:0] d);
    for (int k = 0; k < 8; k++) mset_word(bbase(a) + k, d[32*k +: 32]);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wwrite(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    data_address_2DM    = a;
    data_write_2DM      = d;
    data_write_size_2DM = s;
    MemWrite_2DM        = 1'b1;
    tick();
    MemWrite_2DM = 1'b0;
    mwrite(a, d, s);
  endtask

  task automatic rcheck(input string tag, input logic [31:0] a);
    data_address_2DM = a;
    #1;
    chk(tag, data_read_fDM, mword(widx(a)));
  endtask

  // Issue one block request, measure the cycle its valid appears (request
  // raised in cycle 0). Optionally fire a colliding word write on the last
  // wait cycle of a block write.
  task automatic blk_op(input bit is_wr, input logic [31:0] a, input logic [255:0] d,
                        input bit collide, input string tag);
    int got, stray;
    got = 0;
    stray = 0;
    data_address_2DM = a;
    block_write_2DM  = d;
    if (is_wr) dBlkWrite = 1'b1;
    else       dBlkRead  = 1'b1;
    for (int c = 0; c <= 40 && got == 0; c++) begin
      if (c > 0) begin
        if (is_wr ? block_read_fDM_valid : block_write_fDM_valid) stray++;
        if (is_wr ? block_write_fDM_valid : block_read_fDM_valid) begin
          got = c;
          if (is_wr) mblkwrite(a, d);
          else chk({tag, "_data"}, block_read_fDM, mblock(a));
          dBlkWrite = 1'b0;
          dBlkRead  = 1'b0;
        end
      end
      MemWrite_2DM = 1'b0;
      if (got == 0) begin
        if (collide && c == LAT) begin
          data_address_2DM    = (a & ~32'h1F) + 32'h8;
          data_write_2DM      = 32'hBAD0BAD0;
          data_write_size_2DM = 2'd0;
          MemWrite_2DM        = 1'b1;
        end
        tick();
      end
    end
    dBlkWrite = 1'b0;
    dBlkRead  = 1'b0;
    chk({tag, "_lat"}, 256'(got), 256'(LAT + 1));
    chk({tag, "_stray"}, 256'(stray), 256'd0);
    tick();
  endtask

  initial begin
    logic [255:0] bd;
    logic [31:0]  a;
    int           wc, rc, nv;

    RESET = 1'b0;
    data_address_2DM = '0;
    MemRead_2DM = 1'b0;
    MemWrite_2DM = 1'b0;
    data_write_2DM = '0;
    data_write_size_2DM = '0;
    dBlkRead = 1'b0;
    dBlkWrite = 1'b0;
    block_write_2DM = '0;
    repeat (3) tick();
    chk("rst_rvalid", 256'(block_read_fDM_valid), 256'd0);
    chk("rst_wvalid", 256'(block_write_fDM_valid), 256'd0);
    chk("rst_brdata", block_read_fDM, 256'd0);
    RESET = 1'b1;

    // Give the whole array a known value.
    for (int i = 0; i < WORDS; i++) wwrite(32'(i * 4), 32'h0, 2'd0);

    // Directed word writes.
    wwrite(32'h10, 32'hDEADBEEF, 2'd0);
    wwrite(32'h11, 32'h00000055, 2'd1);
    data_address_2DM = 32'h10; #1;
    chk("w_size1", data_read_fDM, 32'hDE55BEEF);
    wwrite(32'h20, 32'h0, 2'd0);
    wwrite(32'h22, 32'h00001234, 2'd2);
    data_address_2DM = 32'h20; #1;
    chk("w_size2", data_read_fDM, 32'h00001234);
    wwrite(32'h21, 32'h00ABCDEF, 2'd3);
    data_address_2DM = 32'h20; #1;
    chk("w_size3", data_read_fDM, 32'h00ABCDEF);
    // Misaligned: size 3 at offset 2 drops the last byte, next word intact.
    wwrite(32'h24, 32'h11111111, 2'd0);
    wwrite(32'h2A, 32'h00A1B2C3, 2'd3);
    data_address_2DM = 32'h28; #1;
    chk("w_misalign", data_read_fDM, 32'h0000A1B2);
    rcheck("w_nowrap", 32'h2C);

    // Aliasing through ignored upper address bits.
    data_address_2DM = 32'h4000_0010; #1;
    chk("alias_rd", data_read_fDM, 32'hDE55BEEF);

    // Simultaneous read and write: old data this cycle, new data next.
    data_address_2DM    = 32'h30;
    data_write_2DM      = 32'hCAFEF00D;
    data_write_size_2DM = 2'd0;
    MemRead_2DM  = 1'b1;
    MemWrite_2DM = 1'b1;
    #1;
    chk("rw_old", data_read_fDM, mword(widx(32'h30)));
    tick();
    MemWrite_2DM = 1'b0;
    mwrite(32'h30, 32'hCAFEF00D, 2'd0);
    #1;
    chk("rw_new", data_read_fDM, 32'hCAFEF00D);
    MemRead_2DM = 1'b0;

    // Block write of 0x100+k at 0x40, then word and block reads.
    for (int k = 0; k < 8; k++) bd[32*k +: 32] = 32'(32'h100 + k);
    blk_op(1'b1, 32'h40, bd, 1'b0, "bw40");
    data_address_2DM = 32'h40; #1;
    chk("bw40_w0", data_read_fDM, 32'h100);
    data_address_2DM = 32'h5C; #1;
    chk("bw40_w7", data_read_fDM, 32'h107);
    for (int k = 1; k < 7; k++) rcheck("bw40_wk", 32'(32'h40 + 4*k));
    blk_op(1'b0, 32'h44, '0, 1'b0, "br44");
    chk("br44_const", block_read_fDM, bd);

    // Both requests held from cycle 0: write first, read afterwards.
    for (int k = 0; k < 8; k++) bd[32*k +: 32] = $urandom;
    data_address_2DM = 32'h60;
    block_write_2DM  = bd;
    dBlkWrite = 1'b1;
    dBlkRead  = 1'b1;
    wc = 0;
    rc = 0;
    for (int c = 0; c <= 40 && rc == 0; c++) begin
      if (c > 0) begin
        if (block_write_fDM_valid && wc == 0) begin
          wc = c;
          dBlkWrite = 1'b0;
          mblkwrite(32'h60, bd);
        end
        if (block_read_fDM_valid && rc == 0) begin
          rc = c;
          dBlkRead = 1'b0;
          chk("both_data", block_read_fDM, bd);
        end
      end
      if (rc == 0) tick();
    end
    dBlkWrite = 1'b0;
    dBlkRead  = 1'b0;
    chk("both_wlat", 256'(wc), 256'(LAT + 1));
    chk("both_rlat", 256'(rc), 256'(2 * LAT + 3));
    tick();

    // Block write aborted in cycle 2: no valid, array unchanged.
    data_address_2DM = 32'h80;
    block_write_2DM  = {8{32'hFFFF0000}};
    dBlkWrite = 1'b1;
    tick();
    tick();
    dBlkWrite = 1'b0;
    nv = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      nv += int'(block_write_fDM_valid) + int'(block_read_fDM_valid);
    end
    chk("abort_novalid", 256'(nv), 256'd0);
    for (int k = 0; k < 8; k++) rcheck("abort_mem", 32'(32'h80 + 4*k));

    // Reset during READ_WAIT.
    data_address_2DM = 32'h40;
    dBlkRead = 1'b1;
    tick();
    tick();
    RESET    = 1'b0;
    dBlkRead = 1'b0;
    nv = 0;
    tick();
    nv += int'(block_write_fDM_valid) + int'(block_read_fDM_valid);
    chk("rstmid_brdata", block_read_fDM, 256'd0);
    RESET = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      nv += int'(block_write_fDM_valid) + int'(block_read_fDM_valid);
    end
    chk("rstmid_novalid", 256'(nv), 256'd0);
    blk_op(1'b0, 32'h48, '0, 1'b0, "rstmid_rd");

    // Block commit beats a word write on the same edge.
    for (int k = 0; k < 8; k++) bd[32*k +: 32] = $urandom;
    blk_op(1'b1, 32'hA0, bd, 1'b1, "collide");
    data_address_2DM = 32'hA8; #1;
    chk("collide_word", data_read_fDM, bd[95:64]);

    // Randomized word traffic inside a 64-word window with random high bits.
    for (int i = 0; i < 200; i++) begin
      a = $urandom & 32'hFFFF_C0FF;
      wwrite(a, $urandom, 2'($urandom_range(0, 3)));
      rcheck("rnd_wr", a);
      rcheck("rnd_rd", $urandom & 32'hFFFF_C0FF);
    end

    // Randomized block write then read through a different offset.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 8; k++) bd[32*k +: 32] = $urandom;
      a = ($urandom & 32'hFFFF_C0E0) | 32'h100;
      blk_op(1'b1, a, bd, 1'b0, "rnd_bw");
      wwrite(a | 32'h0C, $urandom, 2'($urandom_range(0, 3)));
      blk_op(1'b0, a | 32'(($urandom_range(0, 7)) * 4), '0, 1'b0, "rnd_br");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
